// File: rtl/rot_mul_pkg.sv
// Shared types and helpers for the rotate-then-multiply stage.
package rot_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam int W_DEF = 4;
  localparam int MAX_W = 32;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Swap the upper and lower halves of the low w bits of v.
  function automatic logic [MAX_W-1:0] rotate_half(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = v[(i + w / 2) % w];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_add_step.sv
// One iteration of the shift-add multiplier: conditional add of M into A, then shift {C,A,Q} right.
module shift_add_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] m,
  input  logic [W-1:0] a,
  input  logic [W-1:0] q,
  output logic [W-1:0] a_nxt,
  output logic [W-1:0] q_nxt
);

  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, a};
    if (q[0]) sum = {1'b0, a} + {1'b0, m};
    // The carry lands in A's MSB; the bit shifted in above it is always zero.
    {a_nxt, q_nxt} = {sum, q[W-1:1]};
  end

endmodule

// File: rtl/rot_mul_seq.sv
// Rotate num by half its width, multiply by key over W shift-add cycles, emit a write request.
// Optional even-parity output wr_par is enabled by defining ROT_MUL_PARITY_EN.
module rot_mul_seq
  import rot_mul_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   num,
  input  logic [W-1:0]   key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   wr_addr,
  output logic [2*W-1:0] wr_data
`ifdef ROT_MUL_PARITY_EN
  ,
  output logic           wr_par
`endif
);

  localparam int CW = cnt_width(W);

  state_e         state_q, state_d;
  logic [W-1:0]   m_q, m_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   addr_q, addr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] data_q, data_d;
  logic [W-1:0]   m_rot;
  logic [W-1:0]   a_step, q_step;
`ifdef ROT_MUL_PARITY_EN
  logic           par_q, par_d;
`endif

  assign m_rot = W'(rotate_half(MAX_W'(num), W));

  shift_add_step #(.W(W)) u_step (
    .m     (m_q),
    .a     (a_q),
    .q     (q_q),
    .a_nxt (a_step),
    .q_nxt (q_step)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
`ifdef ROT_MUL_PARITY_EN
    par_d     = par_q;
`endif
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = m_rot;
          a_d     = '0;
          q_d     = key;
          addr_d  = num;
          cnt_d   = CW'(W);
          state_d = BUSY;
        end
      end
      BUSY: begin
        // The count-zero cycle only publishes the product, giving W+1 cycles of latency to DONE.
        if (cnt_q == '0) begin
          data_d  = {a_q, q_q};
`ifdef ROT_MUL_PARITY_EN
          par_d   = ^{a_q, q_q};
`endif
          state_d = DONE;
        end else begin
          a_d   = a_step;
          q_d   = q_step;
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef ROT_MUL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef ROT_MUL_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign wr_addr = addr_q;
  assign wr_data = data_q;
`ifdef ROT_MUL_PARITY_EN
  assign wr_par  = par_q;
`endif

endmodule

// File: tb/tb_rot_mul_seq.sv
// Self-checking bench for rot_mul_seq: directed cases, backpressure, mid-operation reset, random ops.
module tb_rot_mul_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   num;
  logic [W-1:0]   key;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   wr_addr;
  logic [2*W-1:0] wr_data;
`ifdef ROT_MUL_PARITY_EN
  logic           wr_par;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rot_mul_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
`ifdef ROT_MUL_PARITY_EN
    ,
    .wr_par    (wr_par)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: swap the two halves arithmetically, then an ordinary product.
  function automatic int model(input int n, input int k);
    int half_mod;
    int rot;
    half_mod = 1 << (W / 2);
    rot = (n % half_mod) * half_mod + (n / half_mod);
    return rot * k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int n, input int expv);
    logic [2*W-1:0] ev;
    ev = expv[2*W-1:0];
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " wr_addr"}, wr_addr, n);
    check({tag, " wr_data"}, wr_data, expv);
    check({tag, " in_ready_busy"}, in_ready, 0);
`ifdef ROT_MUL_PARITY_EN
    check({tag, " wr_par"}, wr_par, ^ev);
`else
    check({tag, " parity_ref"}, ^wr_data, ^ev);
`endif
  endtask

  task automatic run_op(input int n, input int k, input int stall, input string tag);
    int waitc;
    int expv;
    expv = model(n, k);
    in_valid = 1'b1;
    num = n[W-1:0];
    key = k[W-1:0];
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      step();
      waitc++;
    end
    check({tag, " in_ready_idle"}, in_ready, 1);
    step();
    // Scramble the inputs: only the accept-edge values may matter.
    in_valid = 1'b0;
    num = ~num;
    key = W'($urandom);
    waitc = 0;
    while (!out_valid && waitc < 20) begin
      step();
      waitc++;
    end
    check({tag, " latency"}, waitc, W + 1);
    check_outputs(tag, n, expv);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      num = W'($urandom);
      key = W'($urandom);
      step();
      check_outputs({tag, " stall"}, n, expv);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check({tag, " out_valid_after_hs"}, out_valid, 0);
    check({tag, " in_ready_after_hs"}, in_ready, 1);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    num = '0;
    key = '0;
    repeat (2) step();
    check("reset out_valid", out_valid, 0);
    check("reset wr_data", wr_data, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset in_ready_in_rst", in_ready, 0);
    rst = 1'b0;
    #1;
    check("reset in_ready_released", in_ready, 1);

    run_op(4'b1000, 4'b1000, 0, "c1_2x8");
    run_op(4'b1001, 4'b1000, 0, "c2_6x8");
    run_op(4'b1100, 4'b1010, 0, "c2_3x10");
    run_op(4'b1011, 4'b1110, 6, "c3_14x14_bp");
    run_op(4'b1111, 4'b1111, 0, "c3_15x15");
    run_op(4'b0111, 4'b0000, 0, "key_zero");
    run_op(4'b0000, 4'b1101, 2, "m_zero");

    // Reset during the second BUSY cycle discards the operation.
    in_valid = 1'b1;
    num = 4'b1001;
    key = 4'b1000;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("midrst in_ready_in_rst", in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst wr_data", wr_data, 0);
    check("midrst wr_addr", wr_addr, 0);
    check("midrst in_ready", in_ready, 1);
    seen = 0;
    repeat (8) begin
      step();
      if (out_valid) seen++;
    end
    check("midrst no_stale_output", seen, 0);

    for (int i = 0; i < 20; i++) begin
      run_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, 3)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
